aibcr3_rxdeser_align: RTL and testbench

Word deserializer and alignment-marker lock for one AIB RX slice, clocked on the distributed forwarded clock. Consumes the two DDR bits (`odat0`, `odat1`) that the RX slice produces each `iclkin_dist` cycle. Searches for a parameterised marker at either bit phase, then emits aligned `WORD_W`-bit words. Monitors periodic marker slots to declare loss of lock.

---
 rtl/aibcr3_rxdeser_align.sv | 205 ++++++++++++++++++++
 tb/tb_aibcr3_rxdeser_align.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3_rxdeser_align.sv
// aibcr3_rxdeser_align: AIB RX word deserializer with alignment-marker lock.
// Takes the two DDR bits per iclkin_dist cycle and searches both bit phases
// for MARKER. Once locked, it emits WORD_W-bit words and watches the
// periodic marker slots to detect loss of lock.
// Optional feature: define AIBCR3_RXDESER_MISSCNT_EN to build the saturating
// missed-marker counter on rx_miss_cnt. Without it, the port is tied to zero.
module aibcr3_rxdeser_align #(
  parameter int                WORD_W        = 20,
  parameter logic [WORD_W-1:0] MARKER        = 20'hF0A5C,
  parameter int                MARK_INTERVAL = 16,
  parameter int                MISS_MAX      = 4
) (
  input  logic              iclkin_dist,
  input  logic              irstb,
  input  logic              sync_en,
  input  logic              odat0,
  input  logic              odat1,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_word_vld,
  output logic              rx_marker,
  output logic              rx_mark_err,
  output logic              rx_lock,
  output logic              rx_phase,
  output logic [7:0]        rx_miss_cnt
);

  localparam int HALF = WORD_W / 2;
  localparam int PCW  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int WCW  = (MARK_INTERVAL > 1) ? $clog2(MARK_INTERVAL) : 1;
  localparam logic [PCW-1:0] PC_LAST  = PCW'(HALF - 1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(MARK_INTERVAL - 1);
  localparam logic [WCW-1:0] WC_AFTER0 = (MARK_INTERVAL > 1) ? WCW'(1) : '0;
  localparam logic [3:0]     MISS_LIM = 4'(MISS_MAX);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W:0]   r_sr;
  logic [WORD_W:0]   w_sr_next;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_next;
  logic              r_vld;
  logic              w_vld_next;
  logic              r_marker;
  logic              w_marker_next;
  logic              r_err;
  logic              w_err_next;
  logic              r_phase;
  logic              w_phase_next;
  logic [PCW-1:0]    r_pcnt;
  logic [PCW-1:0]    w_pcnt_next;
  logic [WCW-1:0]    r_wcnt;
  logic [WCW-1:0]    w_wcnt_next;
  logic [3:0]        r_miss_run;
  logic [3:0]        w_miss_run_next;
  logic [3:0]        w_run_inc;
  logic [WORD_W-1:0] w_win_a;
  logic [WORD_W-1:0] w_win_b;
  logic [WORD_W-1:0] w_sel;
  logic              w_match_a;
  logic              w_match_b;

  // Window A ends on the newest odat1 bit. Window B ends on the newest odat0 bit.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi = gi + 1) begin : g_win
      assign w_win_a[gi] = r_sr[gi+1];
      assign w_win_b[gi] = r_sr[gi];
    end
  endgenerate

  assign w_match_a = (w_win_a == MARKER);
  assign w_match_b = (w_win_b == MARKER);
  assign w_run_inc = r_miss_run + 4'd1;

  // Next-state and next-output decode for the search/lock machine
  always_comb begin
    w_state_next    = r_state;
    w_sr_next       = {odat1, odat0, r_sr[WORD_W:2]};
    w_word_next     = r_word;
    w_vld_next      = 1'b0;
    w_marker_next   = 1'b0;
    w_err_next      = 1'b0;
    w_phase_next    = r_phase;
    w_pcnt_next     = r_pcnt;
    w_wcnt_next     = r_wcnt;
    w_miss_run_next = r_miss_run;
    w_sel           = r_phase ? w_win_b : w_win_a;
    case (r_state)
      ST_SEARCH: begin
        if (w_match_a || w_match_b) begin
          // Phase A has priority when both windows hold the marker
          w_state_next    = ST_LOCKED;
          w_phase_next    = ~w_match_a;
          w_word_next     = w_match_a ? w_win_a : w_win_b;
          w_vld_next      = 1'b1;
          w_marker_next   = 1'b1;
          w_pcnt_next     = '0;
          w_wcnt_next     = WC_AFTER0;
          w_miss_run_next = 4'd0;
        end
      end
      default: begin
        if (r_pcnt == PC_LAST) begin
          w_pcnt_next = '0;
          w_word_next = w_sel;
          w_vld_next  = 1'b1;
          w_wcnt_next = (r_wcnt == WC_LAST) ? '0 : r_wcnt + WCW'(1);
          if (r_wcnt == '0) begin
            w_marker_next = 1'b1;
            if (w_sel == MARKER) begin
              w_miss_run_next = 4'd0;
            end else begin
              w_err_next      = 1'b1;
              w_miss_run_next = w_run_inc;
              // The failing word is still emitted. Search restarts on the kept sr.
              if (w_run_inc == MISS_LIM) begin
                w_state_next = ST_SEARCH;
              end
            end
          end
        end else begin
          w_pcnt_next = r_pcnt + PCW'(1);
        end
      end
    endcase
  end

  // State register. A low sync_en holds the machine in search.
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      r_state <= ST_SEARCH;
    end else if (!sync_en) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shift register, counters and registered outputs. Disable clears the partial word.
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      r_sr       <= '0;
      r_word     <= '0;
      r_vld      <= 1'b0;
      r_marker   <= 1'b0;
      r_err      <= 1'b0;
      r_phase    <= 1'b0;
      r_pcnt     <= '0;
      r_wcnt     <= '0;
      r_miss_run <= 4'd0;
    end else if (!sync_en) begin
      r_sr       <= '0;
      r_word     <= '0;
      r_vld      <= 1'b0;
      r_marker   <= 1'b0;
      r_err      <= 1'b0;
      r_phase    <= 1'b0;
      r_pcnt     <= '0;
      r_wcnt     <= '0;
      r_miss_run <= 4'd0;
    end else begin
      r_sr       <= w_sr_next;
      r_word     <= w_word_next;
      r_vld      <= w_vld_next;
      r_marker   <= w_marker_next;
      r_err      <= w_err_next;
      r_phase    <= w_phase_next;
      r_pcnt     <= w_pcnt_next;
      r_wcnt     <= w_wcnt_next;
      r_miss_run <= w_miss_run_next;
    end
  end

`ifdef AIBCR3_RXDESER_MISSCNT_EN
  logic [7:0] r_miss_cnt;

  // Saturating count of bad marker slots. It survives loss of lock.
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      r_miss_cnt <= 8'h00;
    end else if (!sync_en) begin
      r_miss_cnt <= 8'h00;
    end else if (w_err_next && (r_miss_cnt != 8'hFF)) begin
      r_miss_cnt <= r_miss_cnt + 8'd1;
    end
  end

  assign rx_miss_cnt = r_miss_cnt;
`else
  assign rx_miss_cnt = 8'h00;
`endif

  assign rx_word     = r_word;
  assign rx_word_vld = r_vld;
  assign rx_marker   = r_marker;
  assign rx_mark_err = r_err;
  assign rx_lock     = (r_state == ST_LOCKED);
  assign rx_phase    = r_phase;

endmodule

// File: tb/tb_aibcr3_rxdeser_align.sv
// Testbench for aibcr3_rxdeser_align.
// A bit-history model predicts every output on every cycle. Literal checks
// pin lock timing, phase, word contents and the marker-miss behaviour.
module tb_aibcr3_rxdeser_align;
  localparam int W    = 20;
  localparam int HALF = 10;
  localparam int MI   = 16;
  localparam int MMAX = 4;
  localparam logic [W-1:0] MARK = 20'hF0A5C;
`ifdef AIBCR3_RXDESER_MISSCNT_EN
  localparam bit MC_ON = 1'b1;
`else
  localparam bit MC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic irstb = 1'b0;
  logic sync_en = 1'b0;
  logic odat0 = 1'b0;
  logic odat1 = 1'b0;
  logic [W-1:0] rx_word;
  logic rx_word_vld, rx_marker, rx_mark_err, rx_lock, rx_phase;
  logic [7:0] rx_miss_cnt;

  always #5 clk = ~clk;

  aibcr3_rxdeser_align #(
    .WORD_W(W), .MARKER(MARK), .MARK_INTERVAL(MI), .MISS_MAX(MMAX)
  ) dut (
    .iclkin_dist(clk), .irstb(irstb), .sync_en(sync_en),
    .odat0(odat0), .odat1(odat1),
    .rx_word(rx_word), .rx_word_vld(rx_word_vld), .rx_marker(rx_marker),
    .rx_mark_err(rx_mark_err), .rx_lock(rx_lock), .rx_phase(rx_phase),
    .rx_miss_cnt(rx_miss_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int err_pulses = 0;
  int vld_pulses = 0;
  bit chk_on = 1'b0;
  logic rstb_req = 1'b0;
  logic en_req = 1'b0;

  // Expected outputs after the next rising edge
  logic [W-1:0] e_word = '0;
  logic e_vld = 0, e_marker = 0, e_err = 0, e_lock = 0, e_phase = 0;
  int e_miss = 0;

  // Model state: bit history in arrival order, plus lock bookkeeping
  bit hist[$];
  bit m_lock = 0;
  bit m_phase = 0;
  int m_gap = 0;
  int m_idx = 0;
  int m_run = 0;
  int m_miss = 0;

  bit txq[$];
  logic [W-1:0] data[0:199];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] hwin(input int off);
    logic [W-1:0] w;
    int n;
    n = hist.size();
    for (int i = 0; i < W; i++) w[i] = hist[n - W - off + i];
    return w;
  endfunction

  task automatic model_step();
    logic [W-1:0] w;
    if (!irstb || !sync_en) begin
      hist.delete();
      for (int i = 0; i < W + 1; i++) hist.push_back(1'b0);
      e_word = '0; e_vld = 0; e_marker = 0; e_err = 0;
      m_lock = 0; m_phase = 0; m_run = 0; m_miss = 0;
    end else begin
      e_vld = 0; e_marker = 0; e_err = 0;
      if (!m_lock) begin
        if (hwin(0) == MARK || hwin(1) == MARK) begin
          m_phase = (hwin(0) == MARK) ? 1'b0 : 1'b1;
          e_word = MARK; e_vld = 1; e_marker = 1;
          m_lock = 1; m_gap = 0; m_idx = 1; m_run = 0;
        end
      end else begin
        m_gap++;
        if (m_gap == HALF) begin
          m_gap = 0;
          w = hwin(int'(m_phase));
          e_word = w; e_vld = 1;
          if (m_idx % MI == 0) begin
            e_marker = 1;
            if (w == MARK) m_run = 0;
            else begin
              e_err = 1;
              m_run++;
              if (m_miss < 255) m_miss++;
              if (m_run == MMAX) m_lock = 0;
            end
          end
          m_idx++;
        end
      end
      hist.push_back(odat0);
      hist.push_back(odat1);
      while (hist.size() > 64) void'(hist.pop_front());
    end
    e_lock = m_lock;
    e_phase = m_phase;
    e_miss = MC_ON ? m_miss : 0;
  endtask

  // Per-cycle comparison against the model, plus pulse counters
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("rx_word", 32'(rx_word), 32'(e_word));
      chk("rx_word_vld", 32'(rx_word_vld), 32'(e_vld));
      chk("rx_marker", 32'(rx_marker), 32'(e_marker));
      chk("rx_mark_err", 32'(rx_mark_err), 32'(e_err));
      chk("rx_lock", 32'(rx_lock), 32'(e_lock));
      if (e_lock) chk("rx_phase", 32'(rx_phase), 32'(e_phase));
      chk("rx_miss_cnt", 32'(rx_miss_cnt), 32'(e_miss));
      if (rx_word_vld === 1'b1) vld_pulses++;
      if (rx_word_vld === 1'b1 && rx_mark_err === 1'b1) err_pulses++;
    end
  end

  task automatic tick(input logic b0, input logic b1);
    @(negedge clk);
    irstb = rstb_req; sync_en = en_req; odat0 = b0; odat1 = b1;
    model_step();
    chk_on = 1'b1;
  endtask

  task automatic run(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) begin
      a = (txq.size() > 0) ? txq.pop_front() : 1'($urandom_range(0, 1));
      b = (txq.size() > 0) ? txq.pop_front() : 1'($urandom_range(0, 1));
      tick(a, b);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] rword();
    logic [W-1:0] w;
    do w = W'($urandom); while (w == MARK);
    return w;
  endfunction

  // Queue the marker followed by nw-1 words. A set bit in badmask corrupts that marker slot.
  task automatic build_stream(input bit pb, input int nw, input logic [15:0] badmask);
    txq.delete();
    if (pb) txq.push_back(1'($urandom_range(0, 1)));
    data[0] = MARK;
    for (int k = 1; k < nw; k++) begin
      if (k % MI == 0)
        data[k] = badmask[k / MI] ? (MARK ^ W'($urandom_range(1, (1 << W) - 1))) : MARK;
      else
        data[k] = rword();
    end
    for (int k = 0; k < nw; k++)
      for (int i = 0; i < W; i++) txq.push_back(data[k][i]);
  endtask

  task automatic reset_check();
    rstb_req = 1'b0; en_req = 1'b0;
    run(3);
    after_edge();
    chk("rst_word", 32'(rx_word), 32'h0);
    chk("rst_lock", 32'(rx_lock), 32'h0);
    chk("rst_vld", 32'(rx_word_vld), 32'h0);
    chk("rst_miss", 32'(rx_miss_cnt), 32'h0);
  endtask

  task automatic lock_check(input bit pb);
    run(pb ? 11 : 10);
    run(1);
    after_edge();
    chk("lock_lock", 32'(rx_lock), 32'h1);
    chk("lock_phase", 32'(rx_phase), 32'(pb));
    chk("lock_word", 32'(rx_word), 32'(MARK));
    chk("lock_vld", 32'(rx_word_vld), 32'h1);
    chk("lock_marker", 32'(rx_marker), 32'h1);
    err_pulses = 0;
    vld_pulses = 0;
  endtask

  task automatic gap_and_words(input int last);
    for (int j = 1; j <= HALF; j++) begin
      run(1);
      after_edge();
      chk("gap_vld", 32'(rx_word_vld), 32'(j == HALF));
    end
    chk("word1", 32'(rx_word), 32'(data[1]));
    for (int k = 2; k <= last; k++) begin
      run(HALF);
      after_edge();
      chk("wordk", 32'(rx_word), 32'(data[k]));
    end
  endtask

  initial begin
    // Phase A lock
    reset_check();
    build_stream(1'b0, 10, 16'h0000);
    rstb_req = 1'b1; en_req = 1'b1;
    lock_check(1'b0);
    gap_and_words(5);

    // Phase B lock, then marker maintenance over 100 words
    reset_check();
    build_stream(1'b1, 100, 16'h0000);
    rstb_req = 1'b1; en_req = 1'b1;
    lock_check(1'b1);
    gap_and_words(5);
    run(940);
    after_edge();
    chk("maint_word99", 32'(rx_word), 32'(data[99]));
    chk("maint_lock", 32'(rx_lock), 32'h1);
    chk("maint_errs", 32'(err_pulses), 32'd0);
    chk("maint_vlds", 32'(vld_pulses), 32'd99);
    chk("maint_miss", 32'(rx_miss_cnt), 32'd0);

    // Loss of lock: slots 16, 32, 48 and 64 are corrupted
    reset_check();
    build_stream(1'b0, 70, 16'h001E);
    rstb_req = 1'b1; en_req = 1'b1;
    lock_check(1'b0);
    run(639);
    after_edge();
    chk("loss_pre_lock", 32'(rx_lock), 32'h1);
    chk("loss_pre_errs", 32'(err_pulses), 32'd3);
    run(1);
    after_edge();
    chk("loss_lock", 32'(rx_lock), 32'h0);
    chk("loss_vld", 32'(rx_word_vld), 32'h1);
    chk("loss_err", 32'(rx_mark_err), 32'h1);
    chk("loss_errs", 32'(err_pulses), 32'd4);
    chk("loss_miss", 32'(rx_miss_cnt), MC_ON ? 32'd4 : 32'd0);
    run(20);
    after_edge();
    chk("loss_miss_kept", 32'(rx_miss_cnt), MC_ON ? 32'd4 : 32'd0);

    // Recovery: three misses, a good marker, then three more misses
    reset_check();
    build_stream(1'b0, 130, 16'h00EE);
    rstb_req = 1'b1; en_req = 1'b1;
    lock_check(1'b0);
    run(1290);
    after_edge();
    chk("recov_lock", 32'(rx_lock), 32'h1);
    chk("recov_errs", 32'(err_pulses), 32'd6);
    chk("recov_miss", 32'(rx_miss_cnt), MC_ON ? 32'd6 : 32'd0);

    // Disable five cycles into word 3, then relock
    reset_check();
    build_stream(1'b0, 10, 16'h0000);
    rstb_req = 1'b1; en_req = 1'b1;
    lock_check(1'b0);
    run(2 * HALF + 5);
    en_req = 1'b0;
    run(1);
    after_edge();
    chk("dis_word", 32'(rx_word), 32'h0);
    chk("dis_lock", 32'(rx_lock), 32'h0);
    chk("dis_vld", 32'(rx_word_vld), 32'h0);
    chk("dis_phase", 32'(rx_phase), 32'h0);
    vld_pulses = 0;
    run(12);
    after_edge();
    chk("dis_no_word3", 32'(vld_pulses), 32'd0);
    build_stream(1'b0, 4, 16'h0000);
    en_req = 1'b1;
    lock_check(1'b0);
    gap_and_words(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
